// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//
// Self-checking sweeper for a 2-input combinational gate. A start request
// walks {a,b} through 00,01,10,11. Each vector is held for SETTLE_CYCLES
// cycles. The gate's result is sampled on the last cycle of each vector and
// compared against TRUTH_TABLE[{a,b}]. The block reports a mismatch count,
// the first failing vector and a pass flag once the sweep completes.
//
// Parameters:
//   TRUTH_TABLE    expected gate output indexed by {a,b} (default AND)
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   begin a sweep (honoured only when idle or done)
//   result           in   output of the gate under test
//   a, b             out  registered gate stimulus
//   busy             out  sweep in progress
//   done             out  sweep finished, held until the next accepted start
//   pass             out  done with zero mismatches
//   err_count        out  number of mismatching vectors (0..4)
//   first_fail_vec   out  {a,b} of the first mismatch
//   first_fail_valid out  first_fail_vec holds a captured mismatch
//
// Build option:
//   GSC_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep with
//                        {a,b} frozen at the failing vector.

module gate_sweep_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       result,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

`ifdef GSC_STOP_ON_FAIL_EN
  localparam logic StopOnFail = 1'b1;
`else
  localparam logic StopOnFail = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    mismatch  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SETTLE;
          vec_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end

      SETTLE: begin
        if (cnt_q != LastCnt) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          mismatch = (result != TRUTH_TABLE[vec_q]);
          // At most four vectors are judged per sweep, so the 3-bit count
          // tops out at 4 without ever wrapping.
          if (mismatch) begin
            err_d = err_q + 3'd1;
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == 2'd3 || (StopOnFail && mismatch)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            cnt_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The stimulus register doubles as the vector index. It is loaded on
  // start, advanced on each sampling edge and frozen once the sweep ends.
  assign a                = vec_q[1];
  assign b                = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Testbench for gate_sweep_checker. Three instances run side by side:
//   u0: default parameters (AND table, settle 2)
//   u1: SETTLE_CYCLES=1
//   u2: XOR table, settle 3
// Each instance sits next to a behavioural gate whose function is selected
// per cycle. A timeline model predicts every output on every cycle. The model
// works from elapsed cycles since the accepting edge and divides by the settle
// time. Literal expectations from the hand-worked scenarios pin the model.

module tb_gate_sweep_checker;

  localparam int N = 3;
  localparam logic [1:0] G_AND = 2'd0, G_S0 = 2'd1, G_S1 = 2'd2, G_XOR = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       start  [N];
  logic [1:0] mode   [N];
  logic       result [N];
  logic       a_o    [N];
  logic       b_o    [N];
  logic       busy_o [N];
  logic       done_o [N];
  logic       pass_o [N];
  logic [2:0] errc   [N];
  logic [1:0] ffv    [N];
  logic       ffval  [N];

  int checks = 0;
  int errors = 0;

  // model state
  logic       m_run   [N];
  int         m_e     [N];
  logic [1:0] m_ab    [N];
  logic       m_done  [N];
  logic       m_pass  [N];
  logic [2:0] m_err   [N];
  logic [1:0] m_ffv   [N];
  logic       m_ffval [N];

  function automatic int sc_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] tt_of(input int i);
    return (i == 2) ? 4'b0110 : 4'b1000;
  endfunction

  function automatic logic gate(input logic [1:0] m, input logic x, input logic y);
    case (m)
      G_AND:   return x & y;
      G_S0:    return 1'b0;
      G_S1:    return 1'b1;
      default: return x ^ y;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_gut
    assign result[g] = gate(mode[g], a_o[g], b_o[g]);
  end

  gate_sweep_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .result(result[0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(errc[0]), .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .result(result[1]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(errc[1]), .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1])
  );

  gate_sweep_checker #(.TRUTH_TABLE(4'b0110), .SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .result(result[2]),
    .a(a_o[2]), .b(b_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_count(errc[2]), .first_fail_vec(ffv[2]), .first_fail_valid(ffval[2])
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 1'b0; m_e[i] = 0; m_ab[i] = 2'b00; m_done[i] = 1'b0;
      m_pass[i] = 1'b0; m_err[i] = 3'd0; m_ffv[i] = 2'b00; m_ffval[i] = 1'b0;
    end
  endtask

  // Predict the effect of the coming rising edge on instance i.
  task automatic model_step(input int i);
    int         k;
    logic [1:0] v;
    logic [3:0] tt;
    logic       stop;
    if (m_run[i]) begin
      m_e[i] = m_e[i] + 1;
      if (m_e[i] % sc_of(i) == 0) begin
        k    = m_e[i] / sc_of(i) - 1;
        v    = 2'(k);
        tt   = tt_of(i);
        stop = (k == 3);
        if (gate(mode[i], v[1], v[0]) != tt[v]) begin
          m_err[i] = m_err[i] + 3'd1;
          if (!m_ffval[i]) begin
            m_ffval[i] = 1'b1;
            m_ffv[i]   = v;
          end
`ifdef GSC_STOP_ON_FAIL_EN
          stop = 1'b1;
`endif
        end
        if (stop) begin
          m_run[i]  = 1'b0;
          m_done[i] = 1'b1;
          m_pass[i] = (m_err[i] == 3'd0);
        end else begin
          m_ab[i] = v + 2'd1;
        end
      end
    end else if (start[i]) begin
      m_run[i] = 1'b1; m_e[i] = 0; m_ab[i] = 2'b00; m_done[i] = 1'b0;
      m_pass[i] = 1'b0; m_err[i] = 3'd0; m_ffv[i] = 2'b00; m_ffval[i] = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model, then advance the model.
  initial begin
    logic [11:0] got, want;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int i = 0; i < N; i++) begin
        got  = {a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], errc[i], ffv[i], ffval[i]};
        want = {m_ab[i], m_run[i], m_done[i], m_pass[i], m_err[i], m_ffv[i], m_ffval[i]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cycle_cmp u%0d t=%0t got {ab,busy,done,pass,err,ffv,ffval}=%b want %b",
                   i, $time, got, want);
        end
      end
      for (int i = 0; i < N; i++) model_step(i);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Pulse start on instance i; n returns edges from accept to done visible.
  task automatic sweep(input int i, input logic [1:0] m, output int n);
    mode[i]  = m;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    n = 0;
    while (!done_o[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_bound", int'(done_o[i]), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      mode[i]  = G_AND;
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_busy", int'(busy_o[0]), 0);
    chk("reset_done", int'(done_o[0]), 0);
    chk("reset_err", int'(errc[0]), 0);

    // good AND gate, default parameters
    sweep(0, G_AND, n);
    chk("and_latency", n, 8);
    chk("and_pass", int'(pass_o[0]), 1);
    chk("and_err", int'(errc[0]), 0);
    chk("and_ffvalid", int'(ffval[0]), 0);
    chk("and_ab_last", int'({a_o[0], b_o[0]}), 3);

    // stuck at 0: only 11 mismatches
    sweep(0, G_S0, n);
    chk("s0_err", int'(errc[0]), 1);
    chk("s0_ffv", int'(ffv[0]), 3);
    chk("s0_ffvalid", int'(ffval[0]), 1);
    chk("s0_pass", int'(pass_o[0]), 0);

    // stuck at 1: 00,01,10 mismatch
    sweep(0, G_S1, n);
`ifdef GSC_STOP_ON_FAIL_EN
    chk("s1_latency", n, 2);
    chk("s1_err", int'(errc[0]), 1);
    chk("s1_ab", int'({a_o[0], b_o[0]}), 0);
`else
    chk("s1_latency", n, 8);
    chk("s1_err", int'(errc[0]), 3);
`endif
    chk("s1_ffv", int'(ffv[0]), 0);
    chk("s1_pass", int'(pass_o[0]), 0);

    // SETTLE_CYCLES=1 with start held for 10 cycles
    mode[1]  = G_AND;
    start[1] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done_o[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_first_latency", n, 4);
    chk("held_first_pass", int'(pass_o[1]), 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    start[1] = 1'b0;
    n = 0;
    while (!done_o[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_last_done", int'(done_o[1]), 1);
    chk("held_last_pass", int'(pass_o[1]), 1);

    // asynchronous reset during vector 2
`ifdef GSC_STOP_ON_FAIL_EN
    mode[0] = G_AND;
`else
    mode[0] = G_S1;
`endif
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (!(a_o[0] && !b_o[0]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec2", int'({a_o[0], b_o[0]}), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_outputs",
        int'({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], errc[0], ffv[0], ffval[0]}), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sweep(0, G_S1, n);
`ifdef GSC_STOP_ON_FAIL_EN
    chk("post_reset_err", int'(errc[0]), 1);
`else
    chk("post_reset_err", int'(errc[0]), 3);
`endif
    chk("post_reset_pass", int'(pass_o[0]), 0);

    // XOR truth table
    sweep(2, G_XOR, n);
    chk("xor_latency", n, 12);
    chk("xor_pass", int'(pass_o[2]), 1);
    sweep(2, G_AND, n);
`ifdef GSC_STOP_ON_FAIL_EN
    chk("xor_and_err", int'(errc[2]), 1);
`else
    chk("xor_and_err", int'(errc[2]), 3);
`endif
    chk("xor_and_ffv", int'(ffv[2]), 1);

    // randomized phase: random gate modes and start pulses on all instances
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) mode[i] = 2'($urandom_range(0, 3));
      end
    end
    for (int i = 0; i < N; i++) start[i] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking hardware sweeper for a 2-input combinational gate. On `start` it drives every input combination onto the gate under test and holds each one for a configurable settle time. It samples the gate's output and compares it against a parameterised truth table. It reports pass/fail, an error count and the first failing vector. It is the in-silicon counterpart of the gate testbenches: it sits beside a gate instance (e.g. `and_2`), generates its stimulus and judges its `result`.

## Interface
- `TRUTH_TABLE`, default 4'b1000: expected output, indexed by `{a,b}` (bit 3 = a=1,b=1); the default encodes AND.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `result`  in  1  output of the gate under test.
- `a`  out  1  gate input A, registered.
- `b`  out  1  gate input B, registered.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until next accepted `start` or reset.
- `pass`  out  1  1 when `done` and `err_count`==0; 0 otherwise.
- `err_count`  out  3  number of mismatching vectors, 0..4.
- `first_fail_vec`  out  2  `{a,b}` of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured mismatch.

## Operation
- FSM states: IDLE, SETTLE, DONE. Internal: 2-bit `vec`, 4-bit settle counter `cnt`.
- Reset (`rst_n`=0, any time, including mid-sweep): state IDLE; `a`=`b`=0, `busy`=`done`=`pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0, `vec`=`cnt`=0.
- IDLE/DONE with `start`=1: clear `err_count`, `first_fail_*`, `done`, `pass`; set `vec`=0, `{a,b}`=2'b00, `cnt`=0, `busy`=1; go to SETTLE.
- SETTLE, `cnt`<SETTLE_CYCLES-1: `cnt`++.
- SETTLE, `cnt`==SETTLE_CYCLES-1: sample `result` and compare with `TRUTH_TABLE[vec]`.
  - On mismatch: `err_count`++. If `first_fail_valid`==0, load `first_fail_vec`=`vec` and set `first_fail_valid`=1.
  - If `vec`==3 (wrap point): go to DONE, `busy`=0, `done`=1, `pass`=(final count==0). `a`/`b` keep their last values.
  - Otherwise: `vec`++, `{a,b}`=next `vec`, `cnt`=0, stay in SETTLE.
- `start` while in SETTLE is ignored, with no effect on the sweep.
- `err_count` saturates naturally at 4 and never wraps.

## Timing
- Edge E0 accepts `start`. `{a,b}`=00 is visible after E0.
- Vector k is driven for exactly SETTLE_CYCLES cycles. `result` is sampled at edge E0+(k+1)·SETTLE_CYCLES, the same edge that updates `{a,b}` to vector k+1.
- `done`/`pass` rise after edge E0+4·SETTLE_CYCLES. `busy` is high in exactly that window.
- `err_count` and `first_fail_*` update on the sampling edge of the failing vector.
- Restart from DONE: `done` and `pass` drop after the accepting edge, with no gap cycle.

## Configuration
- `GSC_STOP_ON_FAIL_EN`
  - Defined: the first mismatch ends the sweep at its sampling edge. The FSM goes to DONE with `err_count`=1, `pass`=0, `first_fail_*` loaded, and `{a,b}` frozen at the failing vector.
  - Undefined (default): all 4 vectors are always swept and every mismatch is counted.

## Test plan
- Good AND gate, default parameters, `start` pulse → `done` rises 8 cycles after the accepting edge; `pass`=1, `err_count`=0, `first_fail_valid`=0; `{a,b}` sequence 00,01,10,11 with 2 cycles each.
- `result` stuck at 0 → `err_count`=1, `first_fail_vec`=2'b11, `first_fail_valid`=1, `pass`=0.
- `result` stuck at 1 → `err_count`=3, `first_fail_vec`=2'b00, `pass`=0. With `GSC_STOP_ON_FAIL_EN` defined: `done` after 2 cycles, `err_count`=1, `{a,b}`=00.
- SETTLE_CYCLES=1, good gate, `start` held high for 10 cycles → sweep finishes after 4 cycles and restarts on the next edge. Mid-sweep `start` is ignored; each sweep gives `pass`=1.
- `rst_n` pulled low during vector 2 with a stuck-at-1 gate → all outputs return to their reset values immediately. A new `start` then gives a full fresh sweep with `err_count`=3.
- `TRUTH_TABLE`=4'b0110 (XOR) with an XOR gate → `pass`=1. With an AND gate → `err_count`=3, `first_fail_vec`=2'b01.
